// File: rtl/lp_cfg_pkg.sv
// ---------------------------------------------------------------------------
// Module   : lp_cfg_pkg
// Purpose  : Shared types and frame layout constants for the config loader.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package lp_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_IDX  = 3'd2,
      ST_DATA = 3'd3,
      ST_PAR  = 3'd4,
      ST_LAST = 3'd5,
      ST_DONE = 3'd6
   } lp_cfg_state_e;

   // Data word layout: LUT[15:0] occupies the top bits, then switch, then carry-sel.
   localparam int   FRAME_DATA_W = 18;
   localparam int   SW_POS       = 1;
   localparam int   CS_POS       = 0;
   localparam logic SYNC_BIT     = 1'b1;

endpackage : lp_cfg_pkg

`default_nettype wire

// File: rtl/lp_cfg_shift.sv
// ---------------------------------------------------------------------------
// Module   : lp_cfg_shift
// Purpose  : MSB-first serial-in shift register with a field bit counter.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lp_cfg_shift #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_shift,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_data,
   output logic             o_cnt_hit
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_data;

   // High while the next accepted bit is the final bit of the field.
   assign o_cnt_hit = (r_cnt == CNT_W'(WIDTH - 1));
   assign o_data    = r_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_data <= '0;
      end else if (i_clear) begin
         r_cnt  <= '0;
         r_data <= '0;
      end else if (i_shift) begin
         r_data <= (r_data << 1) | WIDTH'(i_bit);
         r_cnt  <= o_cnt_hit ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule : lp_cfg_shift

`default_nettype wire

// File: rtl/lp_config_loader.sv
// ---------------------------------------------------------------------------
// Module   : lp_config_loader
// Purpose  : Bit-serial frame decoder that programs the logic_pair array.
//            Optional even-parity frame check enabled by LP_CFG_PARITY_EN.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lp_config_loader #(
   parameter int NUM_PAIRS = 4,
   parameter int IDX_W     = 2,
   parameter int LUT_W     = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cfg_start,
   input  logic                       cfg_bit,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   output logic [NUM_PAIRS*LUT_W-1:0] look_up_t_bus,
   output logic [NUM_PAIRS-1:0]       switch_bus,
   output logic [NUM_PAIRS-1:0]       carry_sel_bus,
   output logic                       prgm_b,
   output logic [NUM_PAIRS-1:0]       CLB_prgm_b,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   import lp_cfg_pkg::*;

   localparam logic [IDX_W:0] c_num_pairs = (IDX_W + 1)'(NUM_PAIRS);

`ifdef LP_CFG_PARITY_EN
   localparam lp_cfg_state_e c_after_data = ST_PAR;
`else
   localparam lp_cfg_state_e c_after_data = ST_LAST;
`endif

   lp_cfg_state_e r_state;
   lp_cfg_state_e w_state_nxt;

   logic                    r_cfg_ready;
   logic                    r_busy;
   logic                    r_prgm_b;
   logic                    r_done;
   logic                    r_err;

   logic                    w_acc;
   logic                    w_clear;
   logic                    w_start_ok;
   logic                    w_last_acc;
   logic                    w_idx_ok;
   logic                    w_par_ok;
   logic                    w_commit;
   logic                    w_idx_hit;
   logic                    w_data_hit;
   logic [IDX_W-1:0]        w_idx;
   logic [FRAME_DATA_W-1:0] w_data;

   assign w_acc      = cfg_valid & r_cfg_ready;
   assign w_clear    = (r_state == ST_SYNC);
   assign w_start_ok = cfg_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
   assign w_last_acc = w_acc & (r_state == ST_LAST);
   assign w_idx_ok   = ({1'b0, w_idx} < c_num_pairs);
   assign w_commit   = w_last_acc & w_idx_ok & w_par_ok;

   lp_cfg_shift #(.WIDTH(IDX_W)) u_idx_shift (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_clear),
      .i_shift   (w_acc & (r_state == ST_IDX)),
      .i_bit     (cfg_bit),
      .o_data    (w_idx),
      .o_cnt_hit (w_idx_hit)
   );

   lp_cfg_shift #(.WIDTH(FRAME_DATA_W)) u_data_shift (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_clear),
      .i_shift   (w_acc & (r_state == ST_DATA)),
      .i_bit     (cfg_bit),
      .o_data    (w_data),
      .o_cnt_hit (w_data_hit)
   );

`ifdef LP_CFG_PARITY_EN
   logic r_par_bit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_par_bit <= 1'b0;
      end else if (w_acc && (r_state == ST_PAR)) begin
         r_par_bit <= cfg_bit;
      end
   end

   // Even parity: index, data and parity bit together XOR to zero.
   assign w_par_ok = (r_par_bit == (^{w_idx, w_data}));
`else
   assign w_par_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (cfg_start)                       w_state_nxt = ST_SYNC;
         ST_SYNC: if (w_acc && (cfg_bit == SYNC_BIT))  w_state_nxt = ST_IDX;
         ST_IDX:  if (w_acc && w_idx_hit)              w_state_nxt = ST_DATA;
         ST_DATA: if (w_acc && w_data_hit)             w_state_nxt = c_after_data;
`ifdef LP_CFG_PARITY_EN
         ST_PAR:  if (w_acc)                           w_state_nxt = ST_LAST;
`endif
         ST_LAST: if (w_acc)                           w_state_nxt = cfg_bit ? ST_DONE : ST_SYNC;
         ST_DONE: if (cfg_start)                       w_state_nxt = ST_SYNC;
         default:                                      w_state_nxt = ST_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they register alongside it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cfg_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_prgm_b    <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         r_cfg_ready <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
         r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
         r_prgm_b    <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
         r_done      <= (w_state_nxt == ST_DONE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_start_ok) begin
         r_err <= 1'b0;
      end else if (w_last_acc && !(w_idx_ok && w_par_ok)) begin
         r_err <= 1'b1;
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign busy      = r_busy;
   assign prgm_b    = r_prgm_b;
   assign done      = r_done;
   assign err       = r_err;

   for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
      logic             w_sel;
      logic [LUT_W-1:0] r_lut;
      logic             r_sw;
      logic             r_cs;
      logic             r_strobe_n;

      assign w_sel = w_commit && (w_idx == IDX_W'(gi));

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_lut      <= '0;
            r_sw       <= 1'b0;
            r_cs       <= 1'b0;
            r_strobe_n <= 1'b1;
         end else begin
            r_strobe_n <= ~w_sel;
            if (w_sel) begin
               r_lut <= w_data[FRAME_DATA_W-1 -: LUT_W];
               r_sw  <= w_data[SW_POS];
               r_cs  <= w_data[CS_POS];
            end
         end
      end

      assign look_up_t_bus[gi*LUT_W +: LUT_W] = r_lut;
      assign switch_bus[gi]                   = r_sw;
      assign carry_sel_bus[gi]                = r_cs;
      assign CLB_prgm_b[gi]                   = r_strobe_n;
   end

endmodule : lp_config_loader

`default_nettype wire

// File: doc/lp_config_loader.md
Name: lp_config_loader

Overview:
- Serial configuration writer for the logic_pair array.
- Receives a bit-serial bitstream over a valid/ready handshake and decodes addressed frames.
- Drives each pair's 16-bit LUT contents, FF/LUT switch select, carry-out mux select and program strobes.
- Sits between the emulator's host-side bitstream source and the CLB array; it is the producer of the configuration that logic_pair consumes.

Parameters:
- NUM_PAIRS, 4, number of logic pairs configured.
- IDX_W, 2, pair index width; must satisfy 2**IDX_W >= NUM_PAIRS.
- LUT_W, 16, LUT bits per pair.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse that begins a configuration session.
- cfg_bit  in  1  serial bitstream bit.
- cfg_valid  in  1  cfg_bit is valid.
- cfg_ready  out  1  loader accepts a bit this cycle.
- look_up_t_bus  out  NUM_PAIRS*LUT_W  LUT contents; pair i occupies [i*16+15 : i*16].
- switch_bus  out  NUM_PAIRS  FF/LUT output select per pair.
- carry_sel_bus  out  NUM_PAIRS  carryOut_sel_mux per pair.
- prgm_b  out  1  global program enable, low while a session is active.
- CLB_prgm_b  out  NUM_PAIRS  per-pair write strobe, active-low, one cycle.
- busy  out  1  session in progress.
- done  out  1  session completed.
- err  out  1  sticky frame error.

Behaviour:
- Reset values: all config outputs 0; CLB_prgm_b all 1; prgm_b 1; cfg_ready, busy, done and err 0; FSM in IDLE.
- Reset mid-session aborts the session and clears all stored configuration.
- Bit transfer occurs only when cfg_valid & cfg_ready.
- Frame format, in order:
  - sync bit = 1;
  - IDX_W index bits, MSB first;
  - LUT[15] down to LUT[0];
  - switch bit;
  - carry-sel bit;
  - [parity bit, see optional feature];
  - last flag (1 = final frame).
  - Frame length is 22 bits for the defaults.
- FSM states: IDLE, SYNC, IDX, DATA, PAR, LAST, DONE.
- IDLE: cfg_ready=0, busy=0. cfg_start moves to SYNC and clears err and done.
- SYNC: accepted bit 0 is idle fill and is ignored; accepted bit 1 moves to IDX.
- IDX: shift in IDX_W bits, then go to DATA.
- DATA: shift in 18 bits into an 18-bit shift register, then go to PAR (if enabled) or LAST.
- LAST: on acceptance, commit the frame.
  - Commit writes the target pair's LUT, switch and carry-sel registers on that same edge.
  - CLB_prgm_b[idx] goes low for exactly the following cycle.
  - Next state: flag=1 goes to DONE; flag=0 goes to SYNC.
- Index >= NUM_PAIRS: err set; frame dropped with no write and no strobe; sequencing continues normally.
- cfg_ready=1 in SYNC, IDX, DATA, PAR and LAST; otherwise 0.
- busy=1 and prgm_b=0 in every state except IDLE and DONE.
- DONE: done=1, prgm_b=1, cfg_ready=0. cfg_start returns to SYNC; stored configs are kept and only addressed pairs are overwritten.
- cfg_start while busy is ignored.
- Pairs not addressed in a session retain their prior contents.
- Outputs are registered; output-to-LUT latency is 1 cycle after the commit edge.
- Duplicate index within a session: last write wins.

Optional Feature:
- Macro: LP_CFG_PARITY_EN.
- Defined:
  - PAR state inserts one bit after carry-sel, making the frame 23 bits.
  - Even parity is computed over index + 18 data bits.
  - On mismatch: err set, frame not committed, no strobe; the last flag is still honoured.
- Undefined: PAR state and parity logic are absent; frame is 22 bits.

Decomposition:
- Shared package lp_cfg_pkg:
  - FSM state enum;
  - FRAME_DATA_W=18;
  - bit positions SW_POS=1 and CS_POS=0 within the data word;
  - SYNC_BIT constant.
- One sub-module, lp_cfg_shift: serial-in shift register with bit counter and count-reached flag, reused for IDX and DATA.
- Per-pair config storage stays in the top level.

Test Plan:
- Reset then single frame: idx=2, LUT=16'hA5C3, switch=1, csel=0, last=1.
  - look_up_t_bus[47:32]=A5C3, switch_bus=4'b0100.
  - CLB_prgm_b=4'b1011 for 1 cycle; done=1; prgm_b back to 1.
- Four frames for idx 0..3 with LUTs 0001, 0002, 0004, 0008 and last on the fourth.
  - bus=0008_0004_0002_0001; exactly 4 strobes; busy low only after the fourth frame.
- Idle fill plus throttling: 5 zero bits before sync, with cfg_valid toggled 50%.
  - Identical result to the unthrottled run; no bit is lost or duplicated.
- Reconfiguration: after done, cfg_start with idx=1 and LUT=FFFF.
  - Only pair 1 changes; err stays 0.
- Reset asserted mid-DATA of frame 2.
  - All outputs at reset values; a subsequent full session succeeds.
- With LP_CFG_PARITY_EN, send a wrong parity bit for idx=0.
  - err=1, no strobe, pair 0 unchanged.
  - Next frame with correct parity commits.
